// File: rtl/instr_fetch_unit.sv
// Fetch-side initiator: owns the PC, drives the instruction memory, captures into IF/ID.
// Optional feature macro FETCH_PERF_EN enables the delivered-instruction counter.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic        fault,
  output logic [31:0] perf_fetch_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        fault_q, fault_d;
  logic        adv_s;
  logic        accept_s;
  logic        misaligned_s;

  assign adv_s        = (state_q == ST_RUN) && fetch_en && (!id_valid_q || id_ready);
  assign accept_s     = id_valid_q && id_ready;
  assign misaligned_s = |redirect_pc[1:0];

  // Next-state decode for PC, IF/ID entry, FSM and fault flag
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    fault_d    = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          id_valid_d = 1'b0;
        end else begin
          id_valid_d = id_valid_q;
        end
        if (fetch_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect_valid && misaligned_s) begin
          state_d    = ST_FAULT;
          id_valid_d = 1'b0;
          fault_d    = 1'b1;
        end else begin
          if (fetch_en) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
          // A redirect kills the entry (after any same-cycle accept) and costs one bubble
          if (redirect_valid) begin
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
          end else if (adv_s) begin
            id_instr_d = imem_instr;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + PC_INC;
          end else if (accept_s) begin
            id_valid_d = 1'b0;
          end else begin
            id_valid_d = id_valid_q;
          end
        end
      end
      ST_FAULT: begin
        id_valid_d = 1'b0;
        fault_d    = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        id_valid_d = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0000_0000;
      id_pc_q    <= 32'h0000_0000;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      fault_q    <= fault_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  assign perf_d = accept_s ? (perf_q + 32'd1) : perf_q;

  // Delivered-instruction counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= 32'h0000_0000;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_fetch_cnt = perf_q;
`else
  assign perf_fetch_cnt = 32'h0000_0000;
`endif

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: combinational test-program memory plus
// a scoreboard of expected delivered (pc, instr) pairs popped on each decode accept.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        fault;
  logic [31:0] perf_fetch_cnt;

  int tests_run;
  int tests_failed;
  int acc_cnt;
  logic [31:0] exp_q[$];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .fault          (fault),
    .perf_fetch_cnt (perf_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team test program: word i holds 0x2010_0000 + (i<<16) + i, except 0x1C
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {2'b00, a[31:2]};
    if (a == 32'h0000_001C) return 32'h22F7_0001;
    return 32'h2010_0000 + (idx << 16) + idx;
  endfunction

  assign imem_instr = imem_word(imem_addr);

  // One clock: score any accept happening at the coming edge, then land on the negedge
  task automatic cycle();
    logic [31:0] e;
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      acc_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: accepted id_pc=%h, expected no delivery", id_pc);
      end else begin
        e = exp_q.pop_front();
        if ({id_pc, id_instr} !== {e, imem_word(e)}) begin
          tests_failed++;
          $display("FAIL sb_deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                   id_pc, id_instr, e, imem_word(e));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    exp_q.delete();
    acc_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_sb_empty(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_sb_drain: %0d entries still expected, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({id_valid, imem_addr, id_pc, id_instr, fault, perf_fetch_cnt} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b addr=%h pc=%h instr=%h fault=%b perf=%h, expected all 0",
               id_valid, imem_addr, id_pc, id_instr, fault, perf_fetch_cnt);
    end
  endtask

  task automatic test_streaming();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    cycle();
    tests_run++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL stream_idle_to_run: valid=%b addr=%h, expected 0 / 00000000", id_valid, imem_addr);
    end
    cycle();
    tests_run++;
    if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'h0, 32'h2010_0000, 32'h4}) begin
      tests_failed++;
      $display("FAIL stream_first: valid=%b pc=%h instr=%h addr=%h, expected 1/0/20100000/4",
               id_valid, id_pc, id_instr, imem_addr);
    end
    cycle();
    tests_run++;
    if ({id_pc, id_instr} !== {32'h4, 32'h2011_0001}) begin
      tests_failed++;
      $display("FAIL stream_c2: pc=%h instr=%h, expected 00000004/20110001", id_pc, id_instr);
    end
    cycle();
    tests_run++;
    if ({id_pc, id_instr} !== {32'h8, 32'h2012_0002}) begin
      tests_failed++;
      $display("FAIL stream_c3: pc=%h instr=%h, expected 00000008/20120002", id_pc, id_instr);
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b1, 32'h8, 32'h2012_0002, 32'hC}) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h addr=%h, expected 1/8/20120002/C",
                 i, id_valid, id_pc, id_instr, imem_addr);
      end
    end
    id_ready = 1'b1;
    exp_q.push_back(32'hC);
    cycle();
    tests_run++;
    if ({id_valid, id_pc} !== {1'b1, 32'hC}) begin
      tests_failed++;
      $display("FAIL stall_release: valid=%b pc=%h, expected 1/0000000C", id_valid, id_pc);
    end
  endtask

  task automatic test_redirect();
    for (int a = 32'h10; a <= 32'h24; a += 4) exp_q.push_back(32'(a));
    for (int i = 0; i < 6; i++) cycle();
    tests_run++;
    if (id_pc !== 32'h24) begin
      tests_failed++;
      $display("FAIL redir_pre: pc=%h, expected 00000024", id_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h1C;
    exp_q.push_back(32'h1C);
    exp_q.push_back(32'h20);
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h1C}) begin
      tests_failed++;
      $display("FAIL redir_bubble: valid=%b addr=%h, expected 0/0000001C", id_valid, imem_addr);
    end
    cycle();
    tests_run++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h1C, 32'h22F7_0001}) begin
      tests_failed++;
      $display("FAIL redir_target: valid=%b pc=%h instr=%h, expected 1/1C/22F70001",
               id_valid, id_pc, id_instr);
    end
    cycle();
    fetch_en = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h24}) begin
      tests_failed++;
      $display("FAIL redir_idle_hold: valid=%b addr=%h, expected 0/00000024", id_valid, imem_addr);
    end
    check_sb_empty("redirect");
  endtask

  task automatic test_redirect_stalled();
    fetch_en = 1'b1;
    id_ready = 1'b0;
    cycle();
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if ({id_valid, imem_addr} !== {1'b0, 32'h40}) begin
      tests_failed++;
      $display("FAIL redir_stall_kill: valid=%b addr=%h, expected 0/00000040", id_valid, imem_addr);
    end
    id_ready = 1'b1;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    cycle();
    cycle();
    fetch_en = 1'b0;
    cycle();
    check_sb_empty("redir_stall");
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    exp_q.push_back(32'h48);
    exp_q.push_back(32'h4C);
    cycle();
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({id_valid, imem_addr, fault} !== {1'b0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b addr=%h fault=%b, expected 0/00000000/0",
               id_valid, imem_addr, fault);
    end
    exp_q.delete();
    fetch_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fault();
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h2E;
    cycle();
    tests_run++;
    if ({fault, id_valid, imem_addr} !== {1'b1, 1'b0, 32'h4}) begin
      tests_failed++;
      $display("FAIL fault_enter: fault=%b valid=%b addr=%h, expected 1/0/00000004",
               fault, id_valid, imem_addr);
    end
    redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if ({fault, id_valid, imem_addr} !== {1'b1, 1'b0, 32'h4}) begin
      tests_failed++;
      $display("FAIL fault_sticky: fault=%b valid=%b addr=%h, expected 1/0/00000004",
               fault, id_valid, imem_addr);
    end
    check_sb_empty("fault");
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    tests_run++;
    if ({imem_addr, id_pc, fault} !== {32'h0, 32'hFFFF_FFFC, 1'b0}) begin
      tests_failed++;
      $display("FAIL wrap: addr=%h pc=%h fault=%b, expected 00000000/FFFFFFFC/0",
               imem_addr, id_pc, fault);
    end
    cycle();
    fetch_en = 1'b0;
    cycle();
    check_sb_empty("wrap");
  endtask

  task automatic test_perf();
    logic [31:0] exp_perf;
`ifdef FETCH_PERF_EN
    exp_perf = 32'd10;
`else
    exp_perf = 32'd0;
`endif
    do_reset();
    fetch_en = 1'b1;
    for (int a = 0; a < 40; a += 4) exp_q.push_back(32'(a));
    for (int i = 0; i < 40; i++) begin
      if (acc_cnt == 10) break;
      id_ready = (i == 4 || i == 5) ? 1'b0 : 1'b1;
      cycle();
    end
    id_ready = 1'b0;
    fetch_en = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if (acc_cnt != 10 || perf_fetch_cnt !== exp_perf) begin
      tests_failed++;
      $display("FAIL perf_count: accepts=%0d perf=%0d, expected 10 accepts perf=%0d",
               acc_cnt, perf_fetch_cnt, exp_perf);
    end
    check_sb_empty("perf");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    acc_cnt = 0;
    rst_n = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect();
    test_redirect_stalled();
    test_async_reset();
    test_fault();
    test_wrap();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
